// File: rtl/sisc_pkg.sv
// sisc_pkg: shared constants for the SISC execute unit.
// Holds the opcode and ALU function codes, the internal ALU operation
// classes, the sequencer state encoding and the status bit positions.
package sisc_pkg;

  // Opcodes, instr[31:28]
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ALU = 4'b0001;
  localparam logic [3:0] OP_ALI = 4'b0010;
  localparam logic [3:0] OP_BRA = 4'b0100;
  localparam logic [3:0] OP_BRR = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_BNR = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // ALU functions, instr[27:24]
  localparam logic [3:0] FN_NOP = 4'b0000;
  localparam logic [3:0] FN_ADD = 4'b0001;
  localparam logic [3:0] FN_ADC = 4'b0010;
  localparam logic [3:0] FN_SUB = 4'b0011;
  localparam logic [3:0] FN_SBC = 4'b0100;
  localparam logic [3:0] FN_AND = 4'b0101;
  localparam logic [3:0] FN_OR  = 4'b0110;
  localparam logic [3:0] FN_XOR = 4'b0111;
  localparam logic [3:0] FN_NOT = 4'b1000;
  localparam logic [3:0] FN_SHL = 4'b1001;
  localparam logic [3:0] FN_SHR = 4'b1010;
  localparam logic [3:0] FN_ROL = 4'b1011;
  localparam logic [3:0] FN_ROR = 4'b1100;

  // Internal ALU operation classes
  localparam logic [3:0] ALUOP_NONE = 4'b0000;
  localparam logic [3:0] ALUOP_RR   = 4'b0001;
  localparam logic [3:0] ALUOP_RI   = 4'b0011;

  // Status bit positions within {C,N,V,Z}
  localparam int unsigned ST_C = 3;
  localparam int unsigned ST_N = 2;
  localparam int unsigned ST_V = 1;
  localparam int unsigned ST_Z = 0;

  // Sequencer states
  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_e;

endpackage

// File: rtl/sisc_alu_core.sv
// sisc_alu_core: combinational 32-bit ALU with status generation.
// Ports:
//   alu_op_i  [3:0]  operation class; ALUOP_NONE forces a zero result, no flags
//   funct_i   [3:0]  ALU function
//   a_i       [31:0] operand A
//   b_i       [31:0] operand B (register or sign-extended immediate)
//   cin_i            carry flag from the status register (ADC/SBC)
//   out_o     [31:0] result
//   sts_o     [3:0]  computed {C,N,V,Z}
//   en_o      [3:0]  which status bits this function updates
module sisc_alu_core
  import sisc_pkg::*;
(
  input  logic [3:0]  alu_op_i,
  input  logic [3:0]  funct_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] out_o,
  output logic [3:0]  sts_o,
  output logic [3:0]  en_o
);

  logic [32:0] sum;
  logic [31:0] bop;
  logic        cy_in;
  logic [4:0]  sh;
  logic [63:0] shl64, shr64, rol64, ror64;
  logic        c, v;

  assign sh    = b_i[4:0];
  assign shl64 = {32'b0, a_i} << sh;
  assign shr64 = {a_i, 32'b0} >> sh;
  assign rol64 = {a_i, a_i} << sh;
  assign ror64 = {a_i, a_i} >> sh;

  // Subtraction runs through the same adder as A + ~B + carry, so C=1
  // means "no borrow".
  always_comb begin
    bop   = b_i;
    cy_in = 1'b0;
    case (funct_i)
      FN_ADC:  cy_in = cin_i;
      FN_SUB:  begin bop = ~b_i; cy_in = 1'b1;  end
      FN_SBC:  begin bop = ~b_i; cy_in = cin_i; end
      default: ;
    endcase
    sum = {1'b0, a_i} + {1'b0, bop} + {32'b0, cy_in};
  end

  always_comb begin
    out_o = 32'b0;
    c     = 1'b0;
    v     = 1'b0;
    en_o  = 4'b0000;
    if (alu_op_i != ALUOP_NONE) begin
      case (funct_i)
        FN_ADD, FN_ADC, FN_SUB, FN_SBC: begin
          out_o = sum[31:0];
          c     = sum[32];
          v     = (a_i[31] == bop[31]) && (sum[31] != a_i[31]);
          en_o  = 4'b1111;
        end
        FN_AND: begin out_o = a_i & b_i; en_o = 4'b0101; end
        FN_OR:  begin out_o = a_i | b_i; en_o = 4'b0101; end
        FN_XOR: begin out_o = a_i ^ b_i; en_o = 4'b0101; end
        FN_NOT: begin out_o = ~a_i;      en_o = 4'b0101; end
        // Widened shifts leave the last bit shifted out next to the result;
        // a zero shift amount naturally yields C=0.
        FN_SHL: begin out_o = shl64[31:0];  c = shl64[32]; en_o = 4'b1101; end
        FN_SHR: begin out_o = shr64[63:32]; c = shr64[31]; en_o = 4'b1101; end
        FN_ROL: begin
          out_o = rol64[63:32];
          c     = (sh != 5'd0) && rol64[32];
          en_o  = 4'b1101;
        end
        FN_ROR: begin
          out_o = ror64[31:0];
          c     = (sh != 5'd0) && ror64[31];
          en_o  = 4'b1101;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sts_o       = 4'b0000;
    sts_o[ST_C] = c;
    sts_o[ST_N] = out_o[31];
    sts_o[ST_V] = v;
    sts_o[ST_Z] = (out_o == 32'b0);
  end

endmodule

// File: rtl/sisc_exec_unit.sv
// sisc_exec_unit: instruction sequencer, ALU and branch-target logic of the
// SISC processor. Every output is combinational from the state register and
// the current instr/stat/pc_out inputs.
// Ports:
//   clk, rst_f            clock (rising edge), async active-low reset
//   instr [31:0]          IR: opcode[31:28] mm/funct[27:24] imm[15:0]
//   rega, regb [31:0]     register file read ports
//   stat [3:0]            status register {C,N,V,Z}
//   pc_out [15:0]         current (already incremented) PC
//   alu_op [3:0]          ALU operation class
//   alu_out [31:0], alu_sts [3:0], stat_en [3:0]  ALU result/status/enables
//   rf_we, wb_sel         register write enable, writeback select
//   ir_load               IR load enable
//   pc_rst, pc_write, pc_sel, br_sel, br_addr [15:0]  PC control and target
module sisc_exec_unit
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] instr,
  input  logic [31:0] rega,
  input  logic [31:0] regb,
  input  logic [3:0]  stat,
  input  logic [15:0] pc_out,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_out,
  output logic [3:0]  alu_sts,
  output logic [3:0]  stat_en,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        ir_load,
  output logic        pc_rst,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        br_sel,
  output logic [15:0] br_addr
);

  state_e      state_q, state_d;
  logic [3:0]  opcode, mm;
  logic [15:0] imm;
  logic [31:0] opb;
  logic [3:0]  core_en;
  logic        is_alu, is_branch, br_taken;
  logic        unused_fields;

  assign opcode = instr[31:28];
  assign mm     = instr[27:24];
  assign imm    = instr[15:0];
  // Register numbers are consumed by the register file, not here.
  assign unused_fields = ^instr[23:16];

  assign is_alu    = (opcode == OP_ALU) || (opcode == OP_ALI);
  assign is_branch = (opcode[3:2] == 2'b01);

  // BRA/BRR take the branch on any selected flag set (or mm==0);
  // BNE/BNR take it when no selected flag is set.
  always_comb begin
    if (opcode[1]) br_taken = ((stat & mm) == 4'b0);
    else           br_taken = (mm == 4'b0) || ((stat & mm) != 4'b0);
  end

  // Relative targets wrap modulo 2^16, so a plain 16-bit add handles
  // negative offsets.
  assign br_addr = br_sel ? imm : (pc_out + imm);
  assign opb     = (opcode == OP_ALI) ? {{16{imm[15]}}, imm} : regb;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= S_START0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START0:    state_d = S_START1;
      S_START1:    state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_MEM;
      S_MEM:       state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_START0;
    endcase
  end

  always_comb begin
    alu_op   = ALUOP_NONE;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = (state_q == S_START0) || !rst_f;
    case (state_q)
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        if (is_branch) begin
          br_sel   = ~opcode[0];
          pc_write = br_taken;
          pc_sel   = br_taken;
        end
      end
      S_EXECUTE, S_MEM: begin
        if (is_alu) alu_op = (opcode == OP_ALI) ? ALUOP_RI : ALUOP_RR;
      end
      S_WRITEBACK: begin
        if (is_alu) begin
          alu_op = (opcode == OP_ALI) ? ALUOP_RI : ALUOP_RR;
          rf_we  = (mm != FN_NOP);
        end
      end
      default: ;
    endcase
  end

  sisc_alu_core u_alu (
    .alu_op_i (alu_op),
    .funct_i  (mm),
    .a_i      (rega),
    .b_i      (opb),
    .cin_i    (stat[ST_C]),
    .out_o    (alu_out),
    .sts_o    (alu_sts),
    .en_o     (core_en)
  );

  // Status is written once per instruction, in EXECUTE only.
  assign stat_en = (state_q == S_EXECUTE) ? core_en : 4'b0000;

endmodule

// File: tb/tb_sisc_exec_unit.sv
// Directed bench for sisc_exec_unit: reset, ALU, branches and halt.
module tb_sisc_exec_unit;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [31:0] instr, rega, regb;
  logic [3:0]  stat;
  logic [15:0] pc_out;
  logic [3:0]  alu_op, alu_sts, stat_en;
  logic [31:0] alu_out;
  logic        rf_we, wb_sel, ir_load, pc_rst, pc_write, pc_sel, br_sel;
  logic [15:0] br_addr;

  int vectors = 0;
  int miscompares = 0;

  sisc_exec_unit dut (
    .clk(clk), .rst_f(rst_f), .instr(instr), .rega(rega), .regb(regb),
    .stat(stat), .pc_out(pc_out), .alu_op(alu_op), .alu_out(alu_out),
    .alu_sts(alu_sts), .stat_en(stat_en), .rf_we(rf_we), .wb_sel(wb_sel),
    .ir_load(ir_load), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .br_sel(br_sel), .br_addr(br_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {pc_rst, ir_load, pc_write, pc_sel, rf_we, wb_sel}
  function automatic logic [5:0] ctl();
    return {pc_rst, ir_load, pc_write, pc_sel, rf_we, wb_sel};
  endfunction

  initial begin
    rst_f  = 1'b0;
    instr  = 32'h11312000;
    rega   = 32'hFFFFFFFF;
    regb   = 32'h00000001;
    stat   = 4'b0000;
    pc_out = 16'h0010;
    #2;
    chk("reset_ctl", {26'b0, ctl()}, {26'b0, 6'b100000});
    chk("reset_sten", {28'b0, stat_en}, 32'h0);

    // Release and walk to FETCH
    @(negedge clk); rst_f = 1'b1;
    step(); chk("start1_ctl", {26'b0, ctl()}, {26'b0, 6'b000000});
    step(); chk("fetch_ctl", {26'b0, ctl()}, {26'b0, 6'b011000});

    // ADD reg-reg: FFFFFFFF + 1
    step(); chk("add_dec_ctl", {26'b0, ctl()}, 32'h0);
    chk("add_dec_aluop", {28'b0, alu_op}, 32'h0);
    step(); chk("add_ex_aluop", {28'b0, alu_op}, 32'h1);
    chk("add_ex_out", alu_out, 32'h0);
    chk("add_ex_sts", {28'b0, alu_sts}, 32'h9);
    chk("add_ex_sten", {28'b0, stat_en}, 32'hF);
    chk("add_ex_rfwe", {31'b0, rf_we}, 32'h0);
    step(); chk("add_mem_sten", {28'b0, stat_en}, 32'h0);
    chk("add_mem_rfwe", {31'b0, rf_we}, 32'h0);
    step(); chk("add_wb_rfwe", {31'b0, rf_we}, 32'h1);
    chk("add_wb_sten", {28'b0, stat_en}, 32'h0);
    chk("add_wb_wbsel", {31'b0, wb_sel}, 32'h0);

    // ADD immediate with signed overflow, then reset mid-EXECUTE
    step(); chk("fetch2_ctl", {26'b0, ctl()}, {26'b0, 6'b011000});
    instr = 32'h21100001; rega = 32'h7FFFFFFF; regb = 32'h0;
    step();
    step(); chk("addi_aluop", {28'b0, alu_op}, 32'h3);
    chk("addi_out", alu_out, 32'h80000000);
    chk("addi_sts", {28'b0, alu_sts}, 32'h6);
    chk("addi_sten", {28'b0, stat_en}, 32'hF);
    rst_f = 1'b0; #1;
    chk("midrst_ctl", {26'b0, ctl()}, {26'b0, 6'b100000});
    chk("midrst_sten", {28'b0, stat_en}, 32'h0);
    chk("midrst_aluop", {28'b0, alu_op}, 32'h0);
    @(negedge clk); rst_f = 1'b1;
    step(); chk("rst2_start1", {26'b0, ctl()}, 32'h0);
    step(); chk("rst2_fetch", {26'b0, ctl()}, {26'b0, 6'b011000});

    // BRA absolute on Z
    instr = 32'h41000040; stat = 4'b0001;
    step(); chk("bra_brsel", {31'b0, br_sel}, 32'h1);
    chk("bra_addr", {16'b0, br_addr}, 32'h0040);
    chk("bra_taken", {30'b0, pc_write, pc_sel}, 32'h3);
    stat = 4'b0000; #1;
    chk("bra_nottaken", {30'b0, pc_write, pc_sel}, 32'h0);
    step(); chk("bra_ex_sten", {28'b0, stat_en}, 32'h0);
    chk("bra_ex_aluop", {28'b0, alu_op}, 32'h0);
    step(); step(); chk("bra_wb_rfwe", {31'b0, rf_we}, 32'h0);
    step();

    // BNR relative, offset -4
    instr = 32'h7100FFFC; pc_out = 16'h0010; stat = 4'b0000;
    step(); chk("bnr_brsel", {31'b0, br_sel}, 32'h0);
    chk("bnr_addr", {16'b0, br_addr}, 32'h000C);
    chk("bnr_taken", {30'b0, pc_write, pc_sel}, 32'h3);
    stat = 4'b0001; #1;
    chk("bnr_nottaken", {30'b0, pc_write, pc_sel}, 32'h0);
    step(); step(); step(); step();

    // Assorted ALU functions while in EXECUTE (stat C=0)
    instr = 32'h19000000; rega = 32'h80000001; regb = 32'h1; stat = 4'b0000;
    step(); step();
    chk("shl_out", alu_out, 32'h00000002);
    chk("shl_sts", {28'b0, alu_sts}, 32'h8);
    chk("shl_sten", {28'b0, stat_en}, 32'hD);
    instr = 32'h1C000000; rega = 32'h1; regb = 32'h1; #1;
    chk("ror_out", alu_out, 32'h80000000);
    chk("ror_sts", {28'b0, alu_sts}, 32'hC);
    instr = 32'h13000000; rega = 32'h5; regb = 32'h5; #1;
    chk("sub_out", alu_out, 32'h0);
    chk("sub_sts", {28'b0, alu_sts}, 32'h9);
    instr = 32'h14000000; #1;
    chk("sbc_out", alu_out, 32'hFFFFFFFF);
    chk("sbc_sts", {28'b0, alu_sts}, 32'h4);
    instr = 32'h15000000; rega = 32'hF0F0F0F0; regb = 32'h0FF00FF0; #1;
    chk("and_out", alu_out, 32'h00F000F0);
    chk("and_sten", {28'b0, stat_en}, 32'h5);
    instr = 32'h1A000000; rega = 32'h3; regb = 32'h0; #1;
    chk("shr0_out", alu_out, 32'h3);
    chk("shr0_sts", {28'b0, alu_sts}, 32'h0);
    instr = 32'h10000000; #1;
    chk("fnop_sten", {28'b0, stat_en}, 32'h0);
    chk("fnop_out", alu_out, 32'h0);
    step(); step(); chk("fnop_wb_rfwe", {31'b0, rf_we}, 32'h0);
    step();

    // HLT
    instr = 32'hF0000000;
    step(); chk("hlt_dec_pcw", {31'b0, pc_write}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_idle", {26'b0, ctl()}, 32'h0);
    end
    rst_f = 1'b0; #1;
    chk("halt_rst", {26'b0, ctl()}, {26'b0, 6'b100000});
    @(negedge clk); rst_f = 1'b1;
    instr = 32'h00000000;
    step(); chk("halt_start1", {26'b0, ctl()}, 32'h0);
    step(); chk("halt_fetch", {26'b0, ctl()}, {26'b0, 6'b011000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
